// File: rtl/lsu_mmio_pkg.sv
// +----------------------------------------------------------------------+
// | lsu_mmio_pkg : shared enums, address map and lane helpers for LSU    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package lsu_mmio_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [11:0] ADDR_HEX_BASE = 12'h800;
  localparam logic [11:0] ADDR_LEDR     = 12'h880;
  localparam logic [11:0] ADDR_LEDG     = 12'h890;
  localparam logic [11:0] ADDR_LCD      = 12'h8A0;
  localparam logic [11:0] ADDR_SW       = 12'h900;

  function automatic logic [3:0] size_mask(input size_e sz);
    case (sz)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input size_e sz,
                                              input logic sgn);
    case (sz)
      SZ_BYTE: return {{24{sgn & raw[7]}}, raw[7:0]};
      SZ_HALF: return {{16{sgn & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_dmem.sv
// +----------------------------------------------------------------------+
// | lsu_dmem : WORDS x 32-bit RAM, byte write enables, async read        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_dmem #(
  parameter int WORDS = 512
) (
  input  logic                       clk_i,
  input  logic [$clog2(WORDS)-1:0]   addr_i,
  input  logic [3:0]                 be_i,
  input  logic [31:0]                wdata_i,
  output logic [31:0]                rdata_o
);

  logic [3:0][7:0] ram [WORDS];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) ram[addr_i][b] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = ram[addr_i];

endmodule

`default_nettype wire

// File: rtl/lsu_mmio.sv
// +----------------------------------------------------------------------+
// | lsu_mmio : load/store unit with DMEM and HEX/LED/LCD/SW registers    |
// | Option LSU_MMIO_MISALIGN_EN splits word-crossing accesses via ACC2.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_mmio
  import lsu_mmio_pkg::*;
#(
  parameter int DMEM_WORDS = 512,
  parameter int NUM_HEX    = 8,
  parameter int SW_SYNC    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [31:0]               req_addr_i,
  input  logic                      req_we_i,
  input  logic [1:0]                req_size_i,
  input  logic                      req_signed_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      rsp_valid_o,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  input  logic [31:0]               io_sw_i,
  output logic [NUM_HEX-1:0][31:0]  io_hex_o,
  output logic [31:0]               io_ledr_o,
  output logic [31:0]               io_ledg_o,
  output logic [31:0]               io_lcd_o
);

  localparam int AW = $clog2(DMEM_WORDS);

  state_e                   state_q, state_d;
  logic [11:0]              addr_q, addr_d;
  logic                     we_q, we_d;
  size_e                    size_q, size_d;
  logic                     sgn_q, sgn_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [31:0]              lo_q, lo_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic [NUM_HEX-1:0][31:0] hex_q, hex_d;
  logic [31:0]              ledr_q, ledr_d, ledg_q, ledg_d, lcd_q, lcd_d;
  logic [SW_SYNC-1:0][31:0] sw_q, sw_d;

  logic [19:0] unused_addr_hi;
  assign unused_addr_hi = req_addr_i[31:12];

  logic [9:0] word_a;
  logic [1:0] off;
  logic [2:0] hex_idx;
  logic       hit_dmem, hit_hex, hit_ledr, hit_ledg, hit_lcd, hit_sw;
  logic       split, acc_err;

  assign word_a   = addr_q[11:2];
  assign off      = addr_q[1:0];
  assign hex_idx  = addr_q[6:4];
  assign hit_dmem = word_a < 10'(DMEM_WORDS);
  assign hit_hex  = (addr_q[11:7] == ADDR_HEX_BASE[11:7]) && (addr_q[3:2] == 2'b00) &&
                    (int'(hex_idx) < NUM_HEX);
  assign hit_ledr = word_a == ADDR_LEDR[11:2];
  assign hit_ledg = word_a == ADDR_LEDG[11:2];
  assign hit_lcd  = word_a == ADDR_LCD[11:2];
  assign hit_sw   = word_a == ADDR_SW[11:2];

`ifdef LSU_MMIO_MISALIGN_EN
  logic crosses;
  assign crosses = ((size_q == SZ_WORD) && (off != 2'd0)) ||
                   ((size_q == SZ_HALF) && (off == 2'd3));
  assign split   = hit_dmem && crosses;
  assign acc_err = (size_q == SZ_RSVD) ||
                   !(hit_dmem || hit_hex || hit_ledr || hit_ledg || hit_lcd || hit_sw) ||
                   (hit_sw && we_q) ||
                   (split && (word_a == 10'(DMEM_WORDS - 1)));
`else
  logic misal;
  assign misal   = ((size_q == SZ_WORD) && (off != 2'd0)) ||
                   ((size_q == SZ_HALF) && off[0]);
  assign split   = 1'b0;
  assign acc_err = (size_q == SZ_RSVD) ||
                   !(hit_dmem || hit_hex || hit_ledr || hit_ledg || hit_lcd || hit_sw) ||
                   (hit_sw && we_q) ||
                   (hit_dmem && misal);
`endif

  // Byte lanes over a two-word window: low nibble/word is the first word, high the second.
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  assign be_wide = {4'b0000, size_mask(size_q)} << off;
  assign wd_wide = {32'h0, wdata_q} << {off, 3'b000};

  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata, mem_rdata;

  assign mem_addr = word_a[AW-1:0] + AW'(state_q == ACC2);

  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = wd_wide[31:0];
    if ((state_q == ACC) && we_q && hit_dmem && !acc_err) begin
      mem_be = be_wide[3:0];
    end else if ((state_q == ACC2) && we_q) begin
      mem_be    = be_wide[7:4];
      mem_wdata = wd_wide[63:32];
    end
    if (rst_i) mem_be = 4'b0000;
  end

  lsu_dmem #(.WORDS(DMEM_WORDS)) u_dmem (
    .clk_i   (clk_i),
    .addr_i  (mem_addr),
    .be_i    (mem_be),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  logic [63:0] window;
  logic [31:0] load_raw, load_val, mmio_rdata;

  assign window   = (state_q == ACC2) ? {mem_rdata, lo_q} : {32'h0, mem_rdata};
  assign load_raw = 32'(window >> {off, 3'b000});
  assign load_val = load_extend(load_raw, size_q, sgn_q);

  always_comb begin
    mmio_rdata = '0;
    for (int k = 0; k < NUM_HEX; k++) begin
      if (hit_hex && (hex_idx == 3'(k))) mmio_rdata = hex_q[k];
    end
    if (hit_ledr) mmio_rdata = ledr_q;
    if (hit_ledg) mmio_rdata = ledg_q;
    if (hit_lcd)  mmio_rdata = lcd_q;
    if (hit_sw)   mmio_rdata = sw_q[SW_SYNC-1];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    rdata_d = '0;
    err_d   = 1'b0;
    hex_d   = hex_q;
    ledr_d  = ledr_q;
    ledg_d  = ledg_q;
    lcd_d   = lcd_q;
    sw_d[0] = io_sw_i;
    for (int i = 1; i < SW_SYNC; i++) sw_d[i] = sw_q[i-1];

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i[11:0];
          we_d    = req_we_i;
          size_d  = size_e'(req_size_i);
          sgn_d   = req_signed_i;
          wdata_d = req_wdata_i;
          state_d = ACC;
        end
      end
      ACC: begin
        if (acc_err) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (split) begin
          lo_d    = mem_rdata;
          state_d = ACC2;
        end else begin
          state_d = RESP;
          if (hit_dmem) begin
            if (!we_q) rdata_d = load_val;
          end else if (we_q) begin
            for (int k = 0; k < NUM_HEX; k++) begin
              if (hit_hex && (hex_idx == 3'(k))) hex_d[k] = wdata_q;
            end
            if (hit_ledr) ledr_d = wdata_q;
            if (hit_ledg) ledg_d = wdata_q;
            if (hit_lcd)  lcd_d  = wdata_q;
          end else begin
            rdata_d = mmio_rdata;
          end
        end
      end
      ACC2: begin
        state_d = RESP;
        if (!we_q) rdata_d = load_val;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      hex_q   <= '0;
      ledr_q  <= '0;
      ledg_q  <= '0;
      lcd_q   <= '0;
      sw_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      hex_q   <= hex_d;
      ledr_q  <= ledr_d;
      ledg_q  <= ledg_d;
      lcd_q   <= lcd_d;
      sw_q    <= sw_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign io_hex_o    = hex_q;
  assign io_ledr_o   = ledr_q;
  assign io_ledg_o   = ledg_q;
  assign io_lcd_o    = lcd_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mmio.sv
// +----------------------------------------------------------------------+
// | tb_lsu_mmio : directed self-checking bench for lsu_mmio              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_lsu_mmio;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [31:0]      req_addr_i;
  logic             req_we_i;
  logic [1:0]       req_size_i;
  logic             req_signed_i;
  logic [31:0]      req_wdata_i;
  logic             rsp_valid_o;
  logic [31:0]      rsp_rdata_o;
  logic             rsp_err_o;
  logic [31:0]      io_sw_i;
  logic [7:0][31:0] io_hex_o;
  logic [31:0]      io_ledr_o, io_ledg_o, io_lcd_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  lsu_mmio dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_we_i     (req_we_i),
    .req_size_i   (req_size_i),
    .req_signed_i (req_signed_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .io_sw_i      (io_sw_i),
    .io_hex_o     (io_hex_o),
    .io_ledr_o    (io_ledr_o),
    .io_ledg_o    (io_ledg_o),
    .io_lcd_o     (io_lcd_o)
  );

  // lat = cycle index of the response, counting the accept cycle as 0.
  // Inputs are scrambled right after the accept edge to prove they were latched.
  task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard = 0;
    @(negedge clk_i);
    while (!req_ready_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    req_valid_i  = 1'b1;
    req_addr_i   = a;
    req_we_i     = we;
    req_size_i   = sz;
    req_signed_i = sg;
    req_wdata_i  = wd;
    @(posedge clk_i);
    #1;
    req_valid_i  = 1'b0;
    req_addr_i   = 32'hFFFF_FFFF;
    req_we_i     = ~we;
    req_size_i   = 2'b11;
    req_signed_i = ~sg;
    req_wdata_i  = ~wd;
    lat = 1;
    while (lat < 12) begin
      @(posedge clk_i);
      lat++;
      #1;
      if (rsp_valid_o) break;
    end
    rd = rsp_rdata_o;
    er = rsp_err_o;
    total++;
    if (!rsp_valid_o) begin
      bad++;
      $display("FAIL rsp_timeout addr=%h got=no response required=response", a);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b required=1", req_ready_o); end
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b required=0", rsp_valid_o); end
    total++; if (rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h required=0", rsp_rdata_o); end
    total++; if (rsp_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b required=0", rsp_err_o); end
    total++; if (io_hex_o !== '0) begin bad++; $display("FAIL reset_hex got=%h required=0", io_hex_o); end
    total++; if ({io_ledr_o, io_ledg_o, io_lcd_o} !== 96'h0) begin bad++; $display("FAIL reset_leds got=%h required=0", {io_ledr_o, io_ledg_o, io_lcd_o}); end
  endtask

  task automatic test_aligned();
    logic [31:0] rd; logic er; int lat;
    do_req(32'h0000_0010, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, rd, er, lat);
    total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL aligned_store got=err%b/%h required=err0/0", er, rd); end
    total++; if (lat != 2) begin bad++; $display("FAIL aligned_store_lat got=%0d required=2", lat); end
    do_req(32'hABCD_E010, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin bad++; $display("FAIL aligned_load got=%h/err%b required=deadbeef/err0", rd, er); end
    total++; if (lat != 2) begin bad++; $display("FAIL aligned_load_lat got=%0d required=2", lat); end
  endtask

  task automatic test_byte_sign();
    logic [31:0] rd; logic er; int lat;
    do_req(32'h13, 1'b0, 2'b00, 1'b1, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hFFFF_FFDE) begin bad++; $display("FAIL byte_signed got=%h required=ffffffde", rd); end
    do_req(32'h13, 1'b0, 2'b00, 1'b0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h0000_00DE) begin bad++; $display("FAIL byte_unsigned got=%h required=000000de", rd); end
    do_req(32'h12, 1'b0, 2'b01, 1'b1, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hFFFF_DEAD) begin bad++; $display("FAIL half_signed got=%h required=ffffdead", rd); end
    do_req(32'h11, 1'b1, 2'b00, 1'b0, 32'hFFFF_FF55, rd, er, lat);
    do_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hDEAD_55EF) begin bad++; $display("FAIL byte_store_lane got=%h required=dead55ef", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
    do_req(32'h20, 1'b1, 2'b10, 1'b0, 32'hAABB_CCDD, rd, er, lat);
    do_req(32'h24, 1'b1, 2'b10, 1'b0, 32'hAABB_CCDD, rd, er, lat);
    do_req(32'h22, 1'b1, 2'b10, 1'b0, 32'h1122_3344, rd, er, lat);
`ifdef LSU_MMIO_MISALIGN_EN
    total++; if (er !== 1'b0 || lat != 3) begin bad++; $display("FAIL split_store got=err%b/lat%0d required=err0/lat3", er, lat); end
    do_req(32'h22, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h1122_3344 || lat != 3) begin bad++; $display("FAIL split_load got=%h/lat%0d required=11223344/lat3", rd, lat); end
    do_req(32'h20, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h3344_CCDD) begin bad++; $display("FAIL split_word0 got=%h required=3344ccdd", rd); end
    do_req(32'h24, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hAABB_1122) begin bad++; $display("FAIL split_word1 got=%h required=aabb1122", rd); end
    do_req(32'h23, 1'b0, 2'b01, 1'b0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h0000_2233) begin bad++; $display("FAIL split_half got=%h required=00002233", rd); end
`else
    total++; if (er !== 1'b1 || rd !== 32'h0 || lat != 2) begin bad++; $display("FAIL misalign_store got=err%b/%h/lat%0d required=err1/0/lat2", er, rd, lat); end
    do_req(32'h20, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hAABB_CCDD) begin bad++; $display("FAIL misalign_word0 got=%h required=aabbccdd", rd); end
    do_req(32'h24, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hAABB_CCDD) begin bad++; $display("FAIL misalign_word1 got=%h required=aabbccdd", rd); end
    do_req(32'h21, 1'b0, 2'b01, 1'b0, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL misalign_half got=err%b/%h required=err1/0", er, rd); end
    do_req(32'h22, 1'b0, 2'b01, 1'b0, 32'h0, rd, er, lat);
    total++; if (er !== 1'b0 || rd !== 32'h0000_AABB) begin bad++; $display("FAIL aligned_half got=err%b/%h required=err0/0000aabb", er, rd); end
`endif
    // Last DMEM word: any crossing access runs off the end.
    do_req(32'h7FE, 1'b1, 2'b10, 1'b0, 32'h1234_5678, rd, er, lat);
    total++; if (er !== 1'b1 || lat != 2) begin bad++; $display("FAIL dmem_end_cross got=err%b/lat%0d required=err1/lat2", er, lat); end
  endtask

  task automatic test_mmio();
    logic [31:0] rd; logic er; int lat;
    do_req(32'h810, 1'b1, 2'b10, 1'b0, 32'h5, rd, er, lat);
    total++; if (io_hex_o[1] !== 32'h5 || io_hex_o[0] !== 32'h0) begin bad++; $display("FAIL hex1_store got=%h/%h required=00000005/0", io_hex_o[1], io_hex_o[0]); end
    do_req(32'h810, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h5 || er !== 1'b0) begin bad++; $display("FAIL hex1_load got=%h/err%b required=5/err0", rd, er); end
    do_req(32'h880, 1'b1, 2'b00, 1'b0, 32'h1234_5678, rd, er, lat);
    total++; if (io_ledr_o !== 32'h1234_5678) begin bad++; $display("FAIL ledr_full_word got=%h required=12345678", io_ledr_o); end
    do_req(32'h890, 1'b1, 2'b10, 1'b0, 32'h0F0F_0F0F, rd, er, lat);
    total++; if (io_ledg_o !== 32'h0F0F_0F0F) begin bad++; $display("FAIL ledg_store got=%h required=0f0f0f0f", io_ledg_o); end
    do_req(32'h8A0, 1'b1, 2'b10, 1'b0, 32'hC0DE_0001, rd, er, lat);
    do_req(32'h8A0, 1'b0, 2'b01, 1'b0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hC0DE_0001 || io_lcd_o !== 32'hC0DE_0001) begin bad++; $display("FAIL lcd_readback got=%h/%h required=c0de0001", rd, io_lcd_o); end
    io_sw_i = 32'hA5;
    repeat (4) @(posedge clk_i);
    do_req(32'h900, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hA5 || er !== 1'b0) begin bad++; $display("FAIL sw_load got=%h/err%b required=a5/err0", rd, er); end
    do_req(32'h900, 1'b1, 2'b10, 1'b0, 32'h77, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL sw_store got=err%b/%h required=err1/0", er, rd); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic er; int lat;
    do_req(32'h8B0, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL unmapped_8b0 got=err%b/%h required=err1/0", er, rd); end
    do_req(32'h804, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL unmapped_804 got=err%b/%h required=err1/0", er, rd); end
    do_req(32'h10, 1'b0, 2'b11, 1'b0, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL size_rsvd got=err%b/%h required=err1/0", er, rd); end
    do_req(32'h810, 1'b1, 2'b11, 1'b0, 32'h99, rd, er, lat);
    total++; if (io_hex_o[1] !== 32'h5) begin bad++; $display("FAIL size_rsvd_nowrite got=%h required=00000005", io_hex_o[1]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    int pulses = 0;
    int guard = 0;
    do_req(32'h30, 1'b1, 2'b10, 1'b0, 32'h0102_0304, rd, er, lat);
    @(negedge clk_i);
    while (!req_ready_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    req_valid_i = 1'b1;
    req_addr_i  = 32'h30;
    req_we_i    = 1'b1;
    req_size_i  = 2'b10;
    req_wdata_i = 32'hCAFE_F00D;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_mid_ready got=%b required=1", req_ready_o); end
    if (rsp_valid_o) pulses++;
    repeat (3) begin
      @(posedge clk_i);
      #1;
      if (rsp_valid_o) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL reset_mid_rsp got=%0d pulses required=0", pulses); end
    total++; if (io_hex_o[1] !== 32'h0 || io_ledr_o !== 32'h0) begin bad++; $display("FAIL reset_mid_mmio got=%h/%h required=0/0", io_hex_o[1], io_ledr_o); end
    do_req(32'h30, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h0102_0304) begin bad++; $display("FAIL reset_mid_nowrite got=%h required=01020304", rd); end
    do_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hDEAD_55EF) begin bad++; $display("FAIL dmem_kept got=%h required=dead55ef", rd); end
  endtask

  initial begin
    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    req_we_i     = 1'b0;
    req_size_i   = 2'b00;
    req_signed_i = 1'b0;
    req_wdata_i  = '0;
    io_sw_i      = '0;
    test_reset();
    test_aligned();
    test_byte_sign();
    test_misalign();
    test_mmio();
    test_unmapped();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
